// File: rtl/mem_bus_master.sv
// Single-word bus initiator: runs one memory read/write cycle per request and
// completes on MEM_ACK (with timeout) or after a fixed latency.
module mem_bus_master #(
  parameter int unsigned DATAWIDTH_BUS  = 32,
  parameter int unsigned ACK_MODE       = 1,
  parameter int unsigned FIXED_LATENCY  = 2,
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic                     CLK,
  input  logic                     RESET,
  input  logic                     REQ_RD,
  input  logic                     REQ_WR,
  input  logic [DATAWIDTH_BUS-1:0] REQ_ADDRESS,
  input  logic [DATAWIDTH_BUS-1:0] REQ_DATA,
  output logic [DATAWIDTH_BUS-1:0] RDATA,
  output logic                     BUSY,
  output logic                     DONE,
  output logic                     ERR,
  output logic                     MEM_RD,
  output logic                     MEM_WR,
  output logic [DATAWIDTH_BUS-1:0] MEM_ADDRESS,
  output logic [DATAWIDTH_BUS-1:0] MEM_DATA_OUT,
  input  logic [DATAWIDTH_BUS-1:0] MEM_DATA_IN,
  input  logic                     MEM_ACK
);

  localparam int unsigned CntW = ($clog2(TIMEOUT_CYCLES) > 4) ? $clog2(TIMEOUT_CYCLES) : 4;
  localparam logic [CntW-1:0] LatLast = CntW'(FIXED_LATENCY - 1);
  localparam logic [CntW-1:0] ToLast  = CntW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {StIdle, StAccess, StDone} state_e;

  state_e                   state_q, state_d;
  logic [CntW-1:0]          cnt_q, cnt_d;
  logic                     op_wr_q, op_wr_d;
  logic                     err_q, err_d;
  logic [DATAWIDTH_BUS-1:0] addr_q, addr_d;
  logic [DATAWIDTH_BUS-1:0] data_q, data_d;
  logic [DATAWIDTH_BUS-1:0] rdata_q, rdata_d;
  logic                     complete;
  logic                     access;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      op_wr_q <= 1'b0;
      err_q   <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_wr_q <= op_wr_d;
      err_q   <= err_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      rdata_q <= rdata_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    op_wr_d  = op_wr_q;
    err_d    = 1'b0;
    addr_d   = addr_q;
    data_d   = data_q;
    rdata_d  = rdata_q;
    complete = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (REQ_RD ^ REQ_WR) begin
          op_wr_d = REQ_WR;
          addr_d  = REQ_ADDRESS;
          data_d  = REQ_DATA;
          cnt_d   = '0;
          if (REQ_ADDRESS[1:0] == 2'b00) begin
            state_d = StAccess;
          end else begin
            state_d = StDone;
            err_d   = 1'b1;
          end
        end else if (REQ_RD && REQ_WR) begin
          state_d = StDone;
          err_d   = 1'b1;
        end
      end
      StAccess: begin
        cnt_d = cnt_q + 1'b1;
        if (ACK_MODE != 0) begin
          // An ACK on the timeout edge still wins over the timeout.
          if (MEM_ACK) begin
            complete = 1'b1;
          end else if (cnt_q == ToLast) begin
            state_d = StDone;
            err_d   = 1'b1;
          end
        end else if (cnt_q == LatLast) begin
          complete = 1'b1;
        end
        if (complete) begin
          state_d = StDone;
          if (!op_wr_q) rdata_d = MEM_DATA_IN;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  assign access       = (state_q == StAccess);
  assign BUSY         = (state_q != StIdle);
  assign DONE         = (state_q == StDone);
  assign ERR          = DONE & err_q;
  assign MEM_RD       = access & ~op_wr_q;
  assign MEM_WR       = access & op_wr_q;
  assign MEM_ADDRESS  = access ? addr_q : '0;
  assign MEM_DATA_OUT = (access && op_wr_q) ? data_q : '0;
  assign RDATA        = rdata_q;

endmodule
